// File: rtl/proc_noc_ni.sv
// proc_noc_ni: network interface between the pipelined MIPS core and its local NoC router.
// Optional saturating packet/drop counters are compiled in when NI_STATS_EN is defined.
module proc_noc_ni #(
    parameter int FLIT_W   = 34,
    parameter int TX_DEPTH = 4,
    parameter int NODE_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] current_node,
    input  logic              proc_valid,
    input  logic [31:0]       proc_data,
    input  logic [NODE_W-1:0] dest_add,
    output logic              ni_ready,
    input  logic              proc_ready_in,
    output logic [31:0]       wd_NI,
    output logic              data_valid,
    output logic              mips_ni,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_out_valid,
    input  logic              flit_out_ready,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_valid,
    output logic              flit_in_ready,
    output logic              rx_err
`ifdef NI_STATS_EN
    ,
    output logic [15:0]       tx_pkt_cnt,
    output logic [15:0]       rx_pkt_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int ENT_W = NODE_W + 32;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(TX_DEPTH);
    localparam logic [PTR_W:0] ONE_CNT   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] ZERO_CNT  = (PTR_W + 1)'(0);
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b10;

    typedef enum logic [1:0] {T_IDLE = 2'd0, T_HEAD = 2'd1, T_BODY = 2'd2} tx_state_t;
    typedef enum logic [1:0] {R_HEAD = 2'd0, R_BODY = 2'd1, R_HOLD = 2'd2} rx_state_t;

    function automatic logic [FLIT_W-1:0] head_flit(input logic [NODE_W-1:0] src,
                                                    input logic [NODE_W-1:0] dst);
        head_flit = {TYPE_HEAD, {(30 - 2 * NODE_W){1'b0}}, src, 2'b00, dst};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        sat_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic [ENT_W-1:0]  r_mem [TX_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    tx_state_t         r_tx_state;
    logic [FLIT_W-1:0] r_flit_out;
    logic              r_flit_out_valid;
    rx_state_t         r_rx_state;
    logic              r_drop;
    logic [31:0]       r_wd;
    logic              r_data_valid;
    logic              r_in_ready;
    logic              r_rx_err;

    logic [PTR_W:0]    w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_rx_fire;
    logic [PTR_W-1:0]  w_rd_idx;
    logic [PTR_W-1:0]  w_nxt_idx;
    logic [1:0]        w_in_type;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == DEPTH_CNT);
    assign w_empty   = (w_count == ZERO_CNT);
    assign w_push    = proc_valid && !w_full;
    assign w_pop     = (r_tx_state == T_BODY) && r_flit_out_valid && flit_out_ready;
    assign w_rd_idx  = r_rd_ptr[PTR_W-1:0];
    assign w_nxt_idx = w_rd_idx + {{(PTR_W-1){1'b0}}, 1'b1};
    assign w_rx_fire = flit_in_valid && r_in_ready;
    assign w_in_type = flit_in[FLIT_W-1:FLIT_W-2];

    assign ni_ready       = !w_full;
    assign flit_out       = r_flit_out;
    assign flit_out_valid = r_flit_out_valid;
    assign wd_NI          = r_wd;
    assign data_valid     = r_data_valid;
    assign mips_ni        = r_data_valid;
    assign flit_in_ready  = r_in_ready;
    assign rx_err         = r_rx_err;

    // TX FIFO storage: entries carry the destination alongside the data word.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {dest_add, proc_data};
        end
    end

    // TX FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= ZERO_CNT;
            r_rd_ptr <= ZERO_CNT;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ONE_CNT;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE_CNT;
        end
    end

    // TX packetizer: head then body per FIFO entry, flit register held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state       <= T_IDLE;
            r_flit_out       <= {FLIT_W{1'b0}};
            r_flit_out_valid <= 1'b0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (!w_empty) begin
                        r_tx_state       <= T_HEAD;
                        r_flit_out       <= head_flit(current_node, r_mem[w_rd_idx][ENT_W-1:32]);
                        r_flit_out_valid <= 1'b1;
                    end
                end
                T_HEAD: begin
                    if (flit_out_ready) begin
                        r_tx_state <= T_BODY;
                        r_flit_out <= {TYPE_BODY, r_mem[w_rd_idx][31:0]};
                    end
                end
                T_BODY: begin
                    if (flit_out_ready) begin
                        // Chain straight into the next head so back-to-back packets have no bubble.
                        if (w_count > ONE_CNT) begin
                            r_tx_state <= T_HEAD;
                            r_flit_out <= head_flit(current_node, r_mem[w_nxt_idx][ENT_W-1:32]);
                        end else begin
                            r_tx_state       <= T_IDLE;
                            r_flit_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_tx_state       <= T_IDLE;
                    r_flit_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // RX depacketizer: one unconsumed word at most, router stalled while it is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= R_HEAD;
            r_drop       <= 1'b0;
            r_wd         <= 32'd0;
            r_data_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_rx_err <= 1'b0;
            case (r_rx_state)
                R_HEAD: begin
                    r_in_ready <= 1'b1;
                    if (w_rx_fire) begin
                        if (w_in_type == TYPE_HEAD) begin
                            r_rx_state <= R_BODY;
                            r_drop     <= (flit_in[NODE_W-1:0] != current_node);
                            r_rx_err   <= (flit_in[NODE_W-1:0] != current_node);
                        end else begin
                            r_rx_err <= 1'b1;
                        end
                    end
                end
                R_BODY: begin
                    if (w_rx_fire && (w_in_type == TYPE_BODY)) begin
                        if (r_drop) begin
                            r_rx_state <= R_HEAD;
                            r_drop     <= 1'b0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_rx_state   <= R_HOLD;
                            r_wd         <= flit_in[31:0];
                            r_data_valid <= 1'b1;
                            r_in_ready   <= 1'b0;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                        r_rx_err   <= w_rx_fire;
                    end
                end
                R_HOLD: begin
                    if (proc_ready_in) begin
                        r_rx_state   <= R_HEAD;
                        r_data_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_rx_state   <= R_HEAD;
                    r_drop       <= 1'b0;
                    r_data_valid <= 1'b0;
                    r_in_ready   <= 1'b0;
                end
            endcase
        end
    end

`ifdef NI_STATS_EN
    logic [15:0] r_tx_pkt_cnt;
    logic [15:0] r_rx_pkt_cnt;
    logic [15:0] r_drop_cnt;

    assign tx_pkt_cnt = r_tx_pkt_cnt;
    assign rx_pkt_cnt = r_rx_pkt_cnt;
    assign drop_cnt   = r_drop_cnt;

    // Saturating statistics: sent packets, delivered words, dropped flits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_pkt_cnt <= 16'd0;
            r_rx_pkt_cnt <= 16'd0;
            r_drop_cnt   <= 16'd0;
        end else begin
            if (w_pop) r_tx_pkt_cnt <= sat_inc(r_tx_pkt_cnt);
            if ((r_rx_state == R_BODY) && w_rx_fire && (w_in_type == TYPE_BODY) && !r_drop)
                r_rx_pkt_cnt <= sat_inc(r_rx_pkt_cnt);
            if (r_rx_err) r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_proc_noc_ni.sv
// Self-checking bench for proc_noc_ni: directed scenarios plus randomized traffic
// checked against a packet-level reference model.
module tb_proc_noc_ni;
    localparam int FLIT_W = 34;
    localparam int TX_DEPTH = 4;
    localparam int NODE_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NODE_W-1:0] current_node;
    logic              proc_valid;
    logic [31:0]       proc_data;
    logic [NODE_W-1:0] dest_add;
    logic              ni_ready;
    logic              proc_ready_in;
    logic [31:0]       wd_NI;
    logic              data_valid;
    logic              mips_ni;
    logic [FLIT_W-1:0] flit_out;
    logic              flit_out_valid;
    logic              flit_out_ready;
    logic [FLIT_W-1:0] flit_in;
    logic              flit_in_valid;
    logic              flit_in_ready;
    logic              rx_err;
`ifdef NI_STATS_EN
    logic [15:0]       tx_pkt_cnt;
    logic [15:0]       rx_pkt_cnt;
    logic [15:0]       drop_cnt;
`endif

    proc_noc_ni #(.FLIT_W(FLIT_W), .TX_DEPTH(TX_DEPTH), .NODE_W(NODE_W)) dut (
        .clk(clk), .rst(rst), .current_node(current_node),
        .proc_valid(proc_valid), .proc_data(proc_data), .dest_add(dest_add),
        .ni_ready(ni_ready), .proc_ready_in(proc_ready_in), .wd_NI(wd_NI),
        .data_valid(data_valid), .mips_ni(mips_ni), .flit_out(flit_out),
        .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
        .flit_in(flit_in), .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
        .rx_err(rx_err)
`ifdef NI_STATS_EN
        , .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Packet-level reference state.
    logic [FLIT_W-1:0] exp_flits[$];
    int                tx_cnt;
    bit                m_exp_body, m_drop, m_hold, exp_err, rx_acc_prev;
    logic [31:0]       m_word;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] head_of(input logic [1:0] src, input logic [1:0] dst);
        return {2'b01, 26'd0, src, 2'b00, dst};
    endfunction

    function automatic logic [FLIT_W-1:0] body_of(input logic [31:0] d);
        return {2'b10, d};
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        proc_valid = 1'b0; proc_data = 32'd0; dest_add = 2'b00;
        proc_ready_in = 1'b0; flit_out_ready = 1'b0;
        flit_in = '0; flit_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_flit_out_valid", flit_out_valid, 1'b0);
        check_eq("rst_flit_out", flit_out, 34'd0);
        check_eq("rst_data_valid", data_valid, 1'b0);
        check_eq("rst_mips_ni", mips_ni, 1'b0);
        check_eq("rst_wd_NI", wd_NI, 32'd0);
        check_eq("rst_rx_err", rx_err, 1'b0);
        check_eq("rst_ni_ready", ni_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Offer a flit and wait (bounded) for the handshake; returns at the negedge after it.
    task automatic send_flit(input logic [FLIT_W-1:0] f);
        bit done = 1'b0;
        flit_in = f;
        flit_in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (flit_in_ready) done = 1'b1;
            @(negedge clk);
        end
        flit_in_valid = 1'b0;
        if (!done) check_eq("rx_accept_timeout", 1'b0, 1'b1);
    endtask

    function automatic logic [FLIT_W-1:0] gen_flit();
        int r = int'($urandom_range(0, 9));
        logic [1:0] dst = (r < 4) ? current_node : 2'($urandom_range(0, 3));
        logic [1:0] src = 2'($urandom_range(0, 3));
        if (!m_exp_body) begin
            if (r < 6)      return head_of(src, dst);
            else if (r < 8) return body_of($urandom);
            else if (r == 8) return {2'b00, 32'($urandom)};
            else            return {2'b11, 32'($urandom)};
        end else begin
            if (r < 8) return body_of($urandom);
            else       return head_of(src, dst);
        end
    endfunction

    // One cycle at a negedge: compare against the model, drive, then advance the model.
    task automatic step(input bit rnd);
        logic [FLIT_W-1:0] f;
        bit acc;
        check_eq("ni_ready", ni_ready, (tx_cnt < TX_DEPTH));
        if (flit_out_valid) begin
            if (exp_flits.size() == 0) check_eq("tx_spurious_flit", 1'b1, 1'b0);
            else check_eq("flit_out", flit_out, exp_flits[0]);
        end
        check_eq("rx_err", rx_err, exp_err);
        check_eq("data_valid", data_valid, m_hold);
        check_eq("mips_ni", mips_ni, m_hold);
        if (m_hold) check_eq("wd_NI", wd_NI, m_word);
        check_eq("flit_in_ready", flit_in_ready, !m_hold);

        proc_valid     = rnd ? ($urandom_range(0, 2) != 0) : 1'b0;
        proc_data      = $urandom;
        dest_add       = 2'($urandom_range(0, 3));
        flit_out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
        proc_ready_in  = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
        if (rx_acc_prev) flit_in_valid = 1'b0;
        if (!flit_in_valid && rnd && ($urandom_range(0, 1) != 0)) begin
            flit_in = gen_flit();
            flit_in_valid = 1'b1;
        end

        exp_err = 1'b0;
        if (proc_valid && ni_ready) begin
            exp_flits.push_back(head_of(current_node, dest_add));
            exp_flits.push_back(body_of(proc_data));
            tx_cnt++;
        end
        if (flit_out_valid && flit_out_ready && exp_flits.size() != 0) begin
            f = exp_flits.pop_front();
            if (f[33:32] == 2'b10) tx_cnt--;
        end
        acc = flit_in_valid && !m_hold;
        if (m_hold && proc_ready_in) m_hold = 1'b0;
        if (acc) begin
            if (!m_exp_body) begin
                if (flit_in[33:32] == 2'b01) begin
                    m_exp_body = 1'b1;
                    m_drop = (flit_in[1:0] != current_node);
                    exp_err = m_drop;
                end else begin
                    exp_err = 1'b1;
                end
            end else if (flit_in[33:32] == 2'b10) begin
                m_exp_body = 1'b0;
                if (!m_drop) begin
                    m_hold = 1'b1;
                    m_word = flit_in[31:0];
                end
                m_drop = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
        end
        rx_acc_prev = acc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] words[5];
        logic [1:0]  dests[5];
        logic [FLIT_W-1:0] got[$];
        current_node = 2'b01;

        // Single packet latency and format.
        reset_dut();
        flit_out_ready = 1'b1; proc_valid = 1'b1; proc_data = 32'hDEADBEEF; dest_add = 2'b10;
        @(negedge clk);
        proc_valid = 1'b0;
        check_eq("t1_not_yet_valid", flit_out_valid, 1'b0);
        @(negedge clk);
        check_eq("t1_head_valid", flit_out_valid, 1'b1);
        check_eq("t1_head_flit", flit_out, 34'h1_0000_0012);
        @(negedge clk);
        check_eq("t1_body_valid", flit_out_valid, 1'b1);
        check_eq("t1_body_flit", flit_out, 34'h2_DEADBEEF);
        @(negedge clk);
        check_eq("t1_idle_after", flit_out_valid, 1'b0);

        // Fill with router stalled; fifth push refused.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            words[i] = 32'hA5A5_0000 + 32'(i * 17);
            dests[i] = 2'(i);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check_eq("t2_full_ni_ready", ni_ready, 1'b0);
            proc_valid = 1'b1; proc_data = words[i]; dest_add = dests[i];
            @(negedge clk);
        end
        proc_valid = 1'b0;
        check_eq("t2_stall_head", flit_out, head_of(2'b01, dests[0]));
        flit_out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (flit_out_valid) got.push_back(flit_out);
            @(negedge clk);
        end
        check_eq("t2_flit_count", 64'(got.size()), 64'd8);
        for (int i = 0; i < 4; i++) begin
            if (got.size() >= 2 * i + 2) begin
                check_eq("t2_head", got[2*i], head_of(2'b01, dests[i]));
                check_eq("t2_body", got[2*i+1], body_of(words[i]));
            end
        end
        check_eq("t2_ni_ready_drained", ni_ready, 1'b1);

        // RX delivery and hold.
        reset_dut();
        current_node = 2'b11;
        send_flit(head_of(2'b01, 2'b11));
        check_eq("t3_head_no_err", rx_err, 1'b0);
        send_flit(body_of(32'h12345678));
        check_eq("t3_wd_NI", wd_NI, 32'h12345678);
        check_eq("t3_data_valid", data_valid, 1'b1);
        check_eq("t3_mips_ni", mips_ni, 1'b1);
        check_eq("t3_in_ready_low", flit_in_ready, 1'b0);
        for (int k = 0; k < 5; k++) @(negedge clk);
        check_eq("t3_still_held", data_valid, 1'b1);
        check_eq("t3_still_stalled", flit_in_ready, 1'b0);
        proc_ready_in = 1'b1;
        @(negedge clk);
        proc_ready_in = 1'b0;
        check_eq("t3_consumed", data_valid, 1'b0);
        check_eq("t3_mips_ni_clr", mips_ni, 1'b0);
        check_eq("t3_in_ready_back", flit_in_ready, 1'b1);

        // Misaddressed packet is dropped.
        reset_dut();
        send_flit(head_of(2'b01, 2'b00));
        check_eq("t4_err_pulse", rx_err, 1'b1);
        send_flit(body_of(32'hAAAA5555));
        check_eq("t4_err_once", rx_err, 1'b0);
        check_eq("t4_no_data", data_valid, 1'b0);
        @(negedge clk);
        check_eq("t4_no_data_later", data_valid, 1'b0);
`ifdef NI_STATS_EN
        check_eq("t4_drop_cnt", drop_cnt, 16'd1);
`endif

        // Orphan body, then a good packet.
        send_flit(body_of(32'h0BAD0BAD));
        check_eq("t5_orphan_err", rx_err, 1'b1);
        check_eq("t5_orphan_no_data", data_valid, 1'b0);
        send_flit(head_of(2'b10, 2'b11));
        check_eq("t5_head_ok", rx_err, 1'b0);
        send_flit(body_of(32'hCAFEF00D));
        check_eq("t5_wd_NI", wd_NI, 32'hCAFEF00D);
        check_eq("t5_data_valid", data_valid, 1'b1);
        proc_ready_in = 1'b1;
        @(negedge clk);
        proc_ready_in = 1'b0;

        // Reset between head and body of an outgoing packet.
        reset_dut();
        current_node = 2'b01;
        proc_valid = 1'b1; proc_data = 32'h55AA55AA; dest_add = 2'b11;
        @(negedge clk);
        proc_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_head_stalled", flit_out_valid, 1'b1);
        flit_out_ready = 1'b1;
        @(negedge clk);
        check_eq("t6_body_pending", flit_out, body_of(32'h55AA55AA));
        flit_out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_valid_cleared", flit_out_valid, 1'b0);
        check_eq("t6_ni_ready", ni_ready, 1'b1);
        rst = 1'b0;
        flit_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) @(negedge clk);
        check_eq("t6_no_partial", flit_out_valid, 1'b0);

        // Randomized traffic against the model.
        reset_dut();
        current_node = 2'($urandom_range(0, 3));
        exp_flits.delete();
        tx_cnt = 0; m_exp_body = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
        exp_err = 1'b0; rx_acc_prev = 1'b0; m_word = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            step(1'b1);
            @(negedge clk);
        end
        for (int c = 0; c < 60; c++) begin
            step(1'b0);
            @(negedge clk);
        end
        check_eq("rand_tx_drained", 64'(tx_cnt), 64'd0);
        check_eq("rand_flits_drained", 64'(exp_flits.size()), 64'd0);
        check_eq("rand_out_idle", flit_out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
